id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS datapath, sitting directly upstream of the 32-bit alu (a, b, control[2:0] -> result, zero).
- Captures decoded operands and control from the ID stage.
- Performs ALU-control decode and ALUSrc/RegDst selection, and presents registered a, b and control to the alu.
- Carries MEM/WB control bits forward and supports stall (hold) and flush (bubble insertion).

---
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 tb/tb_id_ex_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register feeding the 32-bit alu. Decodes ALU control,
// selects the b operand (register or extended immediate) and the
// destination register, and carries MEM/WB control bits forward.
// Every output comes straight from a flop (one-cycle latency).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall, flush        hold all registers / insert bubble (flush wins)
//   in_valid            ID stage presents a real instruction
//   in_rd1, in_rd2      register-file read data (rs, rt)
//   in_imm16            instruction[15:0], funct = in_imm16[5:0]
//   in_rt, in_rd        candidate destination register indices
//   in_aluop            00 add, 01 sub, 10 R-type funct, 11 ori
//   in_alusrc           1: b from immediate, 0: b from in_rd2
//   in_regdst           1: dest from in_rd, 0: from in_rt
//   in_regwrite/memread/memwrite/memtoreg  downstream control
//   alu_a, alu_b, alu_control              registered alu inputs
//   ex_store_data       registered in_rd2 (store data)
//   ex_wr_reg           registered destination register
//   ex_valid            stage holds a real instruction
//   ex_regwrite/memread/memwrite/memtoreg  registered control
//   illegal_op          registered: unsupported R-type funct
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_rd1,
  input  logic [DW-1:0] in_rd2,
  input  logic [15:0]   in_imm16,
  input  logic [RW-1:0] in_rt,
  input  logic [RW-1:0] in_rd,
  input  logic [1:0]    in_aluop,
  input  logic          in_alusrc,
  input  logic          in_regdst,
  input  logic          in_regwrite,
  input  logic          in_memread,
  input  logic          in_memwrite,
  input  logic          in_memtoreg,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_control,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_wr_reg,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          illegal_op
);

  logic [DW-1:0] alu_a_q, alu_b_q, store_q;
  logic [DW-1:0] alu_b_d, ext_imm;
  logic [2:0]    ctl_q, ctl_d;
  logic [RW-1:0] wr_reg_q, wr_reg_d;
  logic          valid_q, regwrite_q, memread_q, memwrite_q, memtoreg_q, illegal_q;
  logic          illegal_d;
  logic          bubble;

  // ori zero-extends; every other ALUOp sign-extends.
  assign ext_imm  = (in_aluop == 2'b11) ? {{(DW-16){1'b0}}, in_imm16}
                                        : {{(DW-16){in_imm16[15]}}, in_imm16};
  assign alu_b_d  = in_alusrc ? ext_imm : in_rd2;
  assign wr_reg_d = in_regdst ? in_rd : in_rt;

  always_comb begin
    ctl_d     = 3'b010;
    illegal_d = 1'b0;
    unique case (in_aluop)
      2'b00: ctl_d = 3'b010;
      2'b01: ctl_d = 3'b110;
      2'b11: ctl_d = 3'b001;
      default: begin
        unique case (in_imm16[5:0])
          6'b100000: ctl_d = 3'b010;
          6'b100010: ctl_d = 3'b110;
          6'b100100: ctl_d = 3'b000;
          6'b100101: ctl_d = 3'b001;
          6'b101010: ctl_d = 3'b111;
          default: begin
            ctl_d     = 3'b010;
            illegal_d = 1'b1;
          end
        endcase
      end
    endcase
  end

  // A load with no real instruction is indistinguishable from a flush.
  assign bubble = flush | (~stall & ~in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      store_q    <= '0;
      ctl_q      <= '0;
      wr_reg_q   <= '0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (bubble) begin
      // Datapath registers hold; only the qualifying bits clear.
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (!stall) begin
      alu_a_q    <= in_rd1;
      alu_b_q    <= alu_b_d;
      store_q    <= in_rd2;
      ctl_q      <= ctl_d;
      wr_reg_q   <= wr_reg_d;
      valid_q    <= 1'b1;
      // An illegal funct neutralises side effects but stays valid.
      regwrite_q <= in_regwrite & ~illegal_d;
      memread_q  <= in_memread  & ~illegal_d;
      memwrite_q <= in_memwrite & ~illegal_d;
      memtoreg_q <= in_memtoreg;
      illegal_q  <= illegal_d;
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_control   = ctl_q;
  assign ex_store_data = store_q;
  assign ex_wr_reg     = wr_reg_q;
  assign ex_valid      = valid_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_memtoreg   = memtoreg_q;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by a randomized run,
// all outputs compared after every edge against a reference model.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, in_valid;
  logic [DW-1:0] in_rd1, in_rd2;
  logic [15:0]   in_imm16;
  logic [RW-1:0] in_rt, in_rd;
  logic [1:0]    in_aluop;
  logic          in_alusrc, in_regdst;
  logic          in_regwrite, in_memread, in_memwrite, in_memtoreg;
  logic [DW-1:0] alu_a, alu_b, ex_store_data;
  logic [2:0]    alu_control;
  logic [RW-1:0] ex_wr_reg;
  logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, illegal_op;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [DW-1:0] m_a, m_b, m_sd;
  logic [2:0]    m_ctl;
  logic [RW-1:0] m_wr;
  logic          m_v, m_rw, m_mr, m_mw, m_mt, m_ill;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm16(in_imm16), .in_rt(in_rt), .in_rd(in_rd),
    .in_aluop(in_aluop), .in_alusrc(in_alusrc), .in_regdst(in_regdst),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_memtoreg(in_memtoreg),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_wr_reg(ex_wr_reg), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output logic [2:0] c, output logic ill);
    ill = 1'b0;
    c   = 3'd2;
    if (op == 2'd0) c = 3'd2;
    else if (op == 2'd1) c = 3'd6;
    else if (op == 2'd3) c = 3'd1;
    else if (f == 6'd32) c = 3'd2;
    else if (f == 6'd34) c = 3'd6;
    else if (f == 6'd36) c = 3'd0;
    else if (f == 6'd37) c = 3'd1;
    else if (f == 6'd42) c = 3'd7;
    else ill = 1'b1;
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_sd = 0; m_ctl = 0; m_wr = 0;
    m_v = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mt = 0; m_ill = 0;
  endtask

  task automatic model_edge();
    logic [2:0] c;
    logic       ill;
    longint unsigned ext;
    if (flush || (!stall && !in_valid)) begin
      m_v = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mt = 0; m_ill = 0;
    end else if (!stall) begin
      ref_decode(in_aluop, in_imm16[5:0], c, ill);
      ext = longint'(in_imm16);
      if (in_aluop != 2'd3 && in_imm16 >= 16'd32768) ext = ext + 64'hFFFF_0000;
      m_a   = in_rd1;
      m_b   = in_alusrc ? ext[31:0] : in_rd2;
      m_sd  = in_rd2;
      m_ctl = c;
      m_wr  = in_regdst ? in_rd : in_rt;
      m_v   = 1;
      m_rw  = ill ? 1'b0 : in_regwrite;
      m_mr  = ill ? 1'b0 : in_memread;
      m_mw  = ill ? 1'b0 : in_memwrite;
      m_mt  = in_memtoreg;
      m_ill = ill;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    chk({step, ":alu_a"}, alu_a, m_a);
    chk({step, ":alu_b"}, alu_b, m_b);
    chk({step, ":alu_control"}, 32'(alu_control), 32'(m_ctl));
    chk({step, ":store_data"}, ex_store_data, m_sd);
    chk({step, ":wr_reg"}, 32'(ex_wr_reg), 32'(m_wr));
    chk({step, ":valid"}, 32'(ex_valid), 32'(m_v));
    chk({step, ":regwrite"}, 32'(ex_regwrite), 32'(m_rw));
    chk({step, ":memread"}, 32'(ex_memread), 32'(m_mr));
    chk({step, ":memwrite"}, 32'(ex_memwrite), 32'(m_mw));
    chk({step, ":memtoreg"}, 32'(ex_memtoreg), 32'(m_mt));
    chk({step, ":illegal"}, 32'(illegal_op), 32'(m_ill));
  endtask

  task automatic rand_inputs();
    in_valid    = 1'($urandom);
    in_rd1      = $urandom;
    in_rd2      = $urandom;
    in_imm16    = 16'($urandom);
    in_rt       = RW'($urandom);
    in_rd       = RW'($urandom);
    in_aluop    = 2'($urandom);
    in_alusrc   = 1'($urandom);
    in_regdst   = 1'($urandom);
    in_regwrite = 1'($urandom);
    in_memread  = 1'($urandom);
    in_memwrite = 1'($urandom);
    in_memtoreg = 1'($urandom);
  endtask

  task automatic tick(input string step);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(step);
  endtask

  task automatic set_rtype(input logic [5:0] f);
    rand_inputs();
    in_valid = 1; in_aluop = 2'b10; in_alusrc = 0;
    in_imm16[5:0] = f; in_regwrite = 1;
  endtask

  initial begin
    logic [5:0] fl [6];
    fl[0] = 6'd32; fl[1] = 6'd34; fl[2] = 6'd36; fl[3] = 6'd37; fl[4] = 6'd42; fl[5] = 6'd0;

    stall = 0; flush = 0;
    rst_n = 0;
    rand_inputs();
    model_reset();
    #2;
    check_all("reset");
    tick("reset_edge");
    #2 rst_n = 1;

    // add $3 <- 5 + 7
    rand_inputs();
    in_valid = 1; in_aluop = 2'b10; in_imm16 = 16'h0020; in_rd1 = 5; in_rd2 = 7;
    in_alusrc = 0; in_regdst = 1; in_rd = 3; in_regwrite = 1;
    tick("add");
    chk("add_lit_b", alu_b, 32'd7);
    chk("add_lit_ctl", 32'(alu_control), 32'd2);

    // lw sign extension
    rand_inputs();
    in_valid = 1; in_aluop = 2'b00; in_alusrc = 1; in_imm16 = 16'hFFFC;
    in_rd1 = 32'h100; in_memread = 1; in_regdst = 0;
    tick("lw");
    chk("lw_lit_b", alu_b, 32'hFFFF_FFFC);

    // ori zero extension
    rand_inputs();
    in_valid = 1; in_aluop = 2'b11; in_alusrc = 1; in_imm16 = 16'h8001;
    tick("ori");
    chk("ori_lit_b", alu_b, 32'h0000_8001);
    chk("ori_lit_ctl", 32'(alu_control), 32'd1);

    // funct sweep, including an unsupported funct
    for (int i = 0; i < 6; i++) begin
      set_rtype(fl[i]);
      tick($sformatf("funct%0d", i));
    end
    chk("illegal_lit", 32'(illegal_op), 32'd1);
    chk("illegal_rw_lit", 32'(ex_regwrite), 32'd0);

    // slt then hold for three stalled cycles
    set_rtype(6'd42);
    tick("slt");
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall = 1;
      tick($sformatf("stall%0d", i));
    end
    flush = 1;
    tick("flush_over_stall");
    stall = 0; flush = 0;
    set_rtype(6'd37);
    tick("reload");
    rand_inputs();
    in_valid = 0;
    tick("invalid_bubble");

    // async reset mid-cycle
    set_rtype(6'd32);
    tick("pre_reset");
    #1 rst_n = 0;
    model_reset();
    #1;
    check_all("async_reset");
    rand_inputs();
    in_valid = 1;
    tick("reset_held");
    #2 rst_n = 1;
    set_rtype(6'd34);
    tick("post_reset_load");

    // randomized run
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      if ($urandom_range(3) != 0) begin
        in_aluop = 2'b10;
        if ($urandom_range(4) != 0) in_imm16[5:0] = fl[$urandom_range(4)];
      end
      stall = ($urandom_range(4) == 0);
      flush = ($urandom_range(7) == 0);
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
